// File: rtl/timer_ip.sv
// timer_ip: 32-bit down-counting timer peripheral with a four-word register map.
//
// Register map (word offset a):
//   0 CTRL   bit0 start/run, bit1 auto-reload, [15:8] prescale (TIMER_PRESCALE_EN only)
//   1 LOAD   32-bit period
//   2 COUNT  current count, read-only
//   3 STATUS bit0 done (write 1 to clear), bit1 busy (read-only)
//
// Ports:
//   clk   sole clock, rising edge
//   rst   synchronous active-high reset
//   we    write strobe
//   a     register word offset
//   wd    write data
//   rd    read data, combinational from a and registered state
//   done  level copy of STATUS.done
//
// Optional feature: define TIMER_PRESCALE_EN to enable the CTRL[15:8] tick prescaler.

module timer_ip (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [1:0]  a,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        done
);

   typedef enum logic {StIdle, StRun} state_e;

`ifdef TIMER_PRESCALE_EN
   localparam logic [31:0] CtrlMask = 32'h0000_ff03;
`else
   localparam logic [31:0] CtrlMask = 32'h0000_0003;
`endif

   state_e      state_q, state_d;
   logic [31:0] ctrl_q, ctrl_d;
   logic [31:0] load_q, load_d;
   logic [31:0] count_q, count_d;
   logic        done_q, done_d;

   logic ctrl_wr, load_wr, sts_wr;
   logic tick;
   logic expire;

   assign ctrl_wr = we && (a == 2'd0);
   assign load_wr = we && (a == 2'd1);
   assign sts_wr  = we && (a == 2'd3);

`ifdef TIMER_PRESCALE_EN
   logic [7:0] presc_q, presc_d;

   // >= rather than == keeps the tick alive should the counter ever exceed P.
   assign tick = (state_q == StRun) && (presc_q >= ctrl_q[15:8]);

   always_comb begin
      presc_d = presc_q;
      if (state_q == StRun) begin
         presc_d = tick ? 8'd0 : presc_q + 8'd1;
      end
      // Start and restart both realign the prescaler.
      if (ctrl_wr && wd[0]) begin
         presc_d = 8'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= 8'd0;
      end else begin
         presc_q <= presc_d;
      end
   end
`else
   assign tick = (state_q == StRun);
`endif

   always_comb begin
      state_d = state_q;
      ctrl_d  = ctrl_q;
      load_d  = load_q;
      count_d = count_q;
      done_d  = done_q;
      expire  = 1'b0;

      if (load_wr) begin
         load_d = wd;
      end
      if (ctrl_wr) begin
         ctrl_d = wd & CtrlMask;
      end

      unique case (state_q)
         StIdle: begin
            // A start with LOAD=0 only stores CTRL.
            if (ctrl_wr && wd[0] && (load_q != 32'd0)) begin
               state_d = StRun;
               count_d = load_q;
            end
         end
         StRun: begin
            if (ctrl_wr) begin
               // Bus writes to CTRL take priority over a coincident tick.
               if (wd[0]) begin
                  count_d = load_q;
                  if (load_q == 32'd0) begin
                     state_d   = StIdle;
                     ctrl_d[0] = 1'b0;
                  end
               end else begin
                  state_d = StIdle;
               end
            end else if (tick) begin
               if (count_q > 32'd1) begin
                  count_d = count_q - 32'd1;
               end else if (count_q == 32'd1) begin
                  expire = 1'b1;
                  // Auto-reload falls back to one-shot when LOAD was cleared.
                  if (ctrl_q[1] && (load_q != 32'd0)) begin
                     count_d = load_q;
                  end else begin
                     count_d   = 32'd0;
                     state_d   = StIdle;
                     ctrl_d[0] = 1'b0;
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Set wins over a same-edge clear.
      if (sts_wr && wd[0]) begin
         done_d = 1'b0;
      end
      if (expire) begin
         done_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         ctrl_q  <= 32'd0;
         load_q  <= 32'd0;
         count_q <= 32'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         load_q  <= load_d;
         count_q <= count_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      rd = 32'd0;
      unique case (a)
         2'd0: rd = ctrl_q;
         2'd1: rd = load_q;
         2'd2: rd = count_q;
         2'd3: rd = {30'd0, (state_q == StRun), done_q};
         default: rd = 32'd0;
      endcase
   end

   assign done = done_q;

endmodule

// File: tb/tb_timer_ip.sv
// tb_timer_ip: scoreboard bench for timer_ip. Expected register values are queued as
// stimulus is applied and drained against the read port between clock edges.

module tb_timer_ip;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [1:0]  a;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        done;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       tag;
      logic [2:0]  sel;  // 0..3 register offset, 4 = done port
      logic [31:0] val;
   } exp_t;

   exp_t sb_q[$];

   timer_ip dut (
      .clk  (clk),
      .rst  (rst),
      .we   (we),
      .a    (a),
      .wd   (wd),
      .rd   (rd),
      .done (done)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] addr, input logic [31:0] data);
      we = 1'b1;
      a  = addr;
      wd = data;
      @(posedge clk);
      #1;
      we = 1'b0;
   endtask

   task automatic push(input string tag, input logic [2:0] sel, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.val = val;
      sb_q.push_back(e);
   endtask

   // Compare every queued expectation; all reads happen inside one clock low/high phase.
   task automatic drain();
      exp_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         if (e.sel == 3'd4) begin
            check_val(e.tag, {31'd0, done}, e.val);
         end else begin
            a = e.sel[1:0];
            #0.5;
            check_val(e.tag, rd, e.val);
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      we  = 1'b0;
      a   = 2'd0;
      wd  = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      push("rst_ctrl", 3'd0, 32'd0);
      push("rst_load", 3'd1, 32'd0);
      push("rst_count", 3'd2, 32'd0);
      push("rst_status", 3'd3, 32'd0);
      push("rst_done", 3'd4, 32'd0);
      drain();

      // One-shot LOAD=5
      wr(2'd1, 32'd5);
      wr(2'd0, 32'd1);
      push("os_count0", 3'd2, 32'd5);
      push("os_busy", 3'd3, 32'd2);
      drain();
      for (int k = 1; k <= 4; k++) begin
         tick_n(1);
         push($sformatf("os_count%0d", k), 3'd2, 32'(5 - k));
         drain();
      end
      tick_n(1);
      push("os_count_end", 3'd2, 32'd0);
      push("os_status_end", 3'd3, 32'd1);
      push("os_ctrl_end", 3'd0, 32'd0);
      push("os_done_port", 3'd4, 32'd1);
      drain();
      tick_n(3);
      push("os_no_wrap", 3'd2, 32'd0);
      drain();
      wr(2'd3, 32'd0);
      push("sts_wr0_noop", 3'd3, 32'd1);
      drain();
      wr(2'd3, 32'd1);
      push("sts_clear", 3'd3, 32'd0);
      drain();

      // Auto-reload LOAD=3, with same-edge clear at second expiry
      wr(2'd1, 32'd3);
      wr(2'd0, 32'd3);
      push("ar_count0", 3'd2, 32'd3);
      drain();
      tick_n(2);
      push("ar_count2", 3'd2, 32'd1);
      push("ar_nodone", 3'd3, 32'd2);
      drain();
      tick_n(1);
      push("ar_exp1_count", 3'd2, 32'd3);
      push("ar_exp1_status", 3'd3, 32'd3);
      drain();
      wr(2'd3, 32'd1);
      push("ar_clear", 3'd3, 32'd2);
      push("ar_count4", 3'd2, 32'd2);
      drain();
      tick_n(1);
      wr(2'd3, 32'd1);
      push("ar_set_wins", 3'd3, 32'd3);
      push("ar_exp2_count", 3'd2, 32'd3);
      drain();
      wr(2'd3, 32'd1);
      push("ar_later_clear", 3'd3, 32'd2);
      drain();
      wr(2'd0, 32'd0);
      push("stop_hold", 3'd2, 32'd2);
      push("stop_status", 3'd3, 32'd0);
      drain();
      tick_n(3);
      push("idle_no_dec", 3'd2, 32'd2);
      drain();

      // LOAD=0 start stays idle
      do_reset();
      wr(2'd1, 32'd0);
      wr(2'd0, 32'd1);
      push("z_ctrl", 3'd0, 32'd1);
      push("z_status", 3'd3, 32'd0);
      push("z_count", 3'd2, 32'd0);
      drain();
      tick_n(5);
      push("z_status_late", 3'd3, 32'd0);
      push("z_count_late", 3'd2, 32'd0);
      drain();

      // Auto-reload with LOAD cleared mid-run becomes one-shot
      wr(2'd1, 32'd2);
      wr(2'd0, 32'd3);
      wr(2'd1, 32'd0);
      push("ld0_count_kept", 3'd2, 32'd1);
      push("ld0_load", 3'd1, 32'd0);
      drain();
      tick_n(1);
      push("ld0_count", 3'd2, 32'd0);
      push("ld0_status", 3'd3, 32'd1);
      push("ld0_ctrl", 3'd0, 32'd2);
      drain();
      wr(2'd3, 32'd1);

      // Restart mid-run and ignored COUNT write
      wr(2'd1, 32'd6);
      wr(2'd0, 32'd1);
      tick_n(2);
      wr(2'd1, 32'd9);
      push("rs_load_no_count", 3'd2, 32'd3);
      drain();
      wr(2'd0, 32'd1);
      push("rs_restart", 3'd2, 32'd9);
      drain();
      wr(2'd2, 32'd123);
      push("count_ro", 3'd2, 32'd8);
      drain();

      // Reset mid-run at COUNT=4 with a coincident write
      do_reset();
      wr(2'd1, 32'd10);
      wr(2'd0, 32'd1);
      tick_n(6);
      push("mr_count4", 3'd2, 32'd4);
      drain();
      rst = 1'b1;
      we  = 1'b1;
      a   = 2'd1;
      wd  = 32'd7;
      @(posedge clk);
      #1;
      rst = 1'b0;
      we  = 1'b0;
      push("mr_ctrl", 3'd0, 32'd0);
      push("mr_load", 3'd1, 32'd0);
      push("mr_count", 3'd2, 32'd0);
      push("mr_status", 3'd3, 32'd0);
      drain();
      tick_n(12);
      push("mr_no_expiry", 3'd3, 32'd0);
      push("mr_done_port", 3'd4, 32'd0);
      drain();

      // Prescaler field
      wr(2'd1, 32'd2);
      wr(2'd0, 32'h0000_0301);
`ifdef TIMER_PRESCALE_EN
      push("ps_ctrl", 3'd0, 32'h0000_0301);
      drain();
      tick_n(3);
      push("ps_hold", 3'd2, 32'd2);
      drain();
      tick_n(1);
      push("ps_dec", 3'd2, 32'd1);
      drain();
      tick_n(3);
      push("ps_nodone", 3'd3, 32'd2);
      drain();
      tick_n(1);
      push("ps_done", 3'd3, 32'd1);
      push("ps_count", 3'd2, 32'd0);
      drain();
      wr(2'd0, 32'hffff_fffc);
      push("ps_unused", 3'd0, 32'h0000_ff00);
      drain();
`else
      push("ps_ctrl", 3'd0, 32'h0000_0001);
      drain();
      tick_n(1);
      push("ps_dec", 3'd2, 32'd1);
      push("ps_nodone", 3'd3, 32'd2);
      drain();
      tick_n(1);
      push("ps_done", 3'd3, 32'd1);
      push("ps_count", 3'd2, 32'd0);
      drain();
      wr(2'd0, 32'hffff_fffc);
      push("ps_unused", 3'd0, 32'h0000_0000);
      drain();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
